mem_responder: RTL

- Memory-side responder for the core's external memory bus: ADDR/BURST/REQ/WRB/WDATA/BSTROBE in; RDATA/ACK/STALL out.
- Backs the bus with an internal word-addressed SRAM array.
- Models first-beat latency and periodic refresh stalls so the cache-line fetch/writeback path is exercised in simulation and on FPGA.
- Services single beats (peripheral-style) and 8-beat line bursts wrapping within a 32-byte line.

---
 rtl/mem_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - SRAM-backed external memory bus responder with first-beat latency and refresh stalls
module mem_responder #(
  parameter int DEPTH_WORDS    = 1024,
  parameter int WAIT_CYCLES    = 2,
  parameter int BURST_LEN      = 8,
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ADDR,
  input  logic [1:0]  BURST,
  input  logic        REQ,
  input  logic        WRB,
  input  logic [31:0] WDATA,
  input  logic [3:0]  BSTROBE,
  output logic [31:0] RDATA,
  output logic        ACK,
  output logic        STALL
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int OB = (BURST_LEN == 8) ? 3 : 2;
  localparam int CW = 16;
  localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REFRESH, S_WAIT, S_DATA, S_DONE} state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] start_idx;
  logic [AW-1:0] beat_idx;
  logic [OB-1:0] beat_cnt;
  logic          single;
  logic [CW-1:0] cnt;
  logic [RW-1:0] refresh_cnt;
  logic          refresh_pending;
  logic          refresh_expire;
  logic          refresh_done;
  logic          beat_fire;
  logic          unused_addr;

  assign unused_addr = &{1'b0, ADDR[31:AW+2], ADDR[1:0]};

  // Line offset wraps inside the burst-aligned block; single beats keep beat_cnt at 0.
  assign beat_idx = {start_idx[AW-1:OB], start_idx[OB-1:0] + beat_cnt};

  assign beat_fire      = (state == S_DATA) && REQ && !reset;
  assign refresh_expire = (REFRESH_PERIOD > 0) && (refresh_cnt == RW'(REFRESH_PERIOD - 1));
  assign refresh_done   = ((state == S_REFRESH) && (cnt == CW'(REFRESH_CYCLES - 1))) ||
                          ((state == S_IDLE) && (REFRESH_CYCLES == 0));

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt     <= '0;
      refresh_pending <= 1'b0;
    end else begin
      if (REFRESH_PERIOD > 0)
        refresh_cnt <= refresh_expire ? '0 : refresh_cnt + 1'b1;
      // An expiry while already pending simply re-asserts the same request.
      if (refresh_expire)
        refresh_pending <= 1'b1;
      else if (refresh_done)
        refresh_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire && WRB) begin
      for (int i = 0; i < 4; i++)
        if (BSTROBE[i]) mem[beat_idx][8*i +: 8] <= WDATA[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      STALL     <= 1'b0;
      ACK       <= 1'b0;
      RDATA     <= '0;
      cnt       <= '0;
      beat_cnt  <= '0;
      start_idx <= '0;
      single    <= 1'b0;
    end else begin
      ACK <= 1'b0;
      case (state)
        S_IDLE: begin
          if (refresh_pending && (REFRESH_CYCLES > 0)) begin
            state <= S_REFRESH;
            STALL <= 1'b1;
            cnt   <= '0;
          end else if (REQ) begin
            start_idx <= ADDR[AW+1:2];
            single    <= (BURST == 2'b00) || (BURST == 2'b11);
            beat_cnt  <= '0;
            cnt       <= '0;
            if (WAIT_CYCLES == 0) begin
              state <= S_DATA;
            end else begin
              state <= S_WAIT;
              STALL <= 1'b1;
            end
          end
        end
        S_REFRESH: begin
          if (refresh_done) begin
            state <= S_IDLE;
            STALL <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (!REQ) begin
            state <= S_IDLE;
            STALL <= 1'b0;
          end else if (cnt == CW'(WAIT_CYCLES - 1)) begin
            state <= S_DATA;
            STALL <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (!REQ) begin
            state <= S_DONE;
          end else begin
            ACK      <= 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
            if (!WRB) RDATA <= mem[beat_idx];
            if (single || (beat_cnt == OB'(BURST_LEN - 1))) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
